// File: rtl/noise_channel_ctrl_if.sv
// CPU-side byte bus into the noise channel register bank.
// The master drives strobes, address and write data; the slave returns registered read data.
interface noise_channel_ctrl_if;
   logic       wr_en;
   logic       rd_en;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (output wr_en, rd_en, addr, wdata, input rdata);
   modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/noise_channel_ctrl.sv
// Noise channel register bank, trigger pulse and 512 Hz frame sequencer (len/env tick enables).
// Define READBACK_EN to make registers readable; otherwise rdata is constant 8'hFF.
module noise_channel_ctrl #(
   parameter int DIV = 8192
) (
   input  logic                clk,
   input  logic                rst_n,
   noise_channel_ctrl_if.slave bus,
   output logic [5:0]          o_length_load,
   output logic [3:0]          o_start_volume,
   output logic                o_env_add,
   output logic [2:0]          o_env_period,
   output logic [3:0]          o_clock_shift,
   output logic                o_width_mode,
   output logic [2:0]          o_divisor_code,
   output logic                o_trigger,
   output logic                o_length_enable,
   output logic                o_len_tick,
   output logic                o_env_tick,
   output logic                o_dac_enabled,
   output logic                o_power,
   output logic [2:0]          o_seq_step
);

   localparam int               DIV_W    = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [5:0]       r_nr41;
   logic [7:0]       r_nr42;
   logic [7:0]       r_nr43;
   logic             r_len_en;
   logic             r_trigger;
   logic             r_power;
   logic             r_len_tick;
   logic             r_env_tick;
   logic [2:0]       r_seq_step;
   logic [DIV_W-1:0] r_div_cnt;

   logic w_wr_nr41, w_wr_nr42, w_wr_nr43, w_wr_nr44, w_wr_nr52;
   logic w_dac;
   logic w_power_off;

   assign w_wr_nr41   = bus.wr_en && (bus.addr == 3'd0);
   assign w_wr_nr42   = bus.wr_en && (bus.addr == 3'd1);
   assign w_wr_nr43   = bus.wr_en && (bus.addr == 3'd2);
   assign w_wr_nr44   = bus.wr_en && (bus.addr == 3'd3);
   assign w_wr_nr52   = bus.wr_en && (bus.addr == 3'd4);
   assign w_dac       = |r_nr42[7:3];
   assign w_power_off = r_power && w_wr_nr52 && !bus.wdata[7];

   // Divider is a down-counter: DIV_LAST is the first step of a frame, zero is the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nr41     <= '0;
         r_nr42     <= '0;
         r_nr43     <= '0;
         r_len_en   <= 1'b0;
         r_trigger  <= 1'b0;
         r_power    <= 1'b0;
         r_len_tick <= 1'b0;
         r_env_tick <= 1'b0;
         r_seq_step <= '0;
         r_div_cnt  <= DIV_LAST;
      end else if (w_power_off) begin
         r_nr41     <= '0;
         r_nr42     <= '0;
         r_nr43     <= '0;
         r_len_en   <= 1'b0;
         r_trigger  <= 1'b0;
         r_power    <= 1'b0;
         r_len_tick <= 1'b0;
         r_env_tick <= 1'b0;
         r_seq_step <= '0;
         r_div_cnt  <= DIV_LAST;
      end else begin
         r_trigger  <= 1'b0;
         r_len_tick <= 1'b0;
         r_env_tick <= 1'b0;
         if (w_wr_nr52) r_power <= bus.wdata[7];
         if (r_power) begin
            if (w_wr_nr41) r_nr41 <= bus.wdata[5:0];
            if (w_wr_nr42) r_nr42 <= bus.wdata;
            if (w_wr_nr43) r_nr43 <= bus.wdata;
            if (w_wr_nr44) begin
               r_len_en  <= bus.wdata[6];
               r_trigger <= bus.wdata[7] && w_dac;
            end
            if (r_div_cnt == '0) begin
               r_div_cnt  <= DIV_LAST;
               r_seq_step <= r_seq_step + 3'd1;
               r_len_tick <= ~r_seq_step[0];
               r_env_tick <= (r_seq_step == 3'd7);
            end else begin
               r_div_cnt <= r_div_cnt - 1'b1;
            end
         end
      end
   end

`ifdef READBACK_EN
   logic [7:0] r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 8'hFF;
      end else if (bus.rd_en) begin
         case (bus.addr)
            3'd1:    r_rdata <= r_nr42;
            3'd2:    r_rdata <= r_nr43;
            3'd3:    r_rdata <= {1'b1, r_len_en, 6'h3F};
            3'd4:    r_rdata <= {r_power, 7'h7F};
            default: r_rdata <= 8'hFF;
         endcase
      end
   end

   assign bus.rdata = r_rdata;
`else
   logic w_unused_rd;

   assign w_unused_rd = bus.rd_en;
   assign bus.rdata   = 8'hFF;
`endif

   assign o_length_load   = r_nr41;
   assign o_start_volume  = r_nr42[7:4];
   assign o_env_add       = r_nr42[3];
   assign o_env_period    = r_nr42[2:0];
   assign o_clock_shift   = r_nr43[7:4];
   assign o_width_mode    = r_nr43[3];
   assign o_divisor_code  = r_nr43[2:0];
   assign o_trigger       = r_trigger;
   assign o_length_enable = r_len_en;
   assign o_len_tick      = r_len_tick;
   assign o_env_tick      = r_env_tick;
   assign o_dac_enabled   = w_dac;
   assign o_power         = r_power;
   assign o_seq_step      = r_seq_step;

endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Bench for noise_channel_ctrl: register-level model compared every cycle, plus directed literal checks.
module tb_noise_channel_ctrl;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst_n;

   noise_channel_ctrl_if u_bus ();

   logic [5:0] o_length_load;
   logic [3:0] o_start_volume;
   logic       o_env_add;
   logic [2:0] o_env_period;
   logic [3:0] o_clock_shift;
   logic       o_width_mode;
   logic [2:0] o_divisor_code;
   logic       o_trigger;
   logic       o_length_enable;
   logic       o_len_tick;
   logic       o_env_tick;
   logic       o_dac_enabled;
   logic       o_power;
   logic [2:0] o_seq_step;

   noise_channel_ctrl #(.DIV(DIV)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (u_bus.slave),
      .o_length_load   (o_length_load),
      .o_start_volume  (o_start_volume),
      .o_env_add       (o_env_add),
      .o_env_period    (o_env_period),
      .o_clock_shift   (o_clock_shift),
      .o_width_mode    (o_width_mode),
      .o_divisor_code  (o_divisor_code),
      .o_trigger       (o_trigger),
      .o_length_enable (o_length_enable),
      .o_len_tick      (o_len_tick),
      .o_env_tick      (o_env_tick),
      .o_dac_enabled   (o_dac_enabled),
      .o_power         (o_power),
      .o_seq_step      (o_seq_step)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: registers as plain bytes; sequencer derived from the count of powered edges.
   int         m_k;
   logic       m_power;
   logic [5:0] m_nr41;
   logic [7:0] m_nr42, m_nr43, m_rdata;
   logic       m_len_en, m_trig, m_len_tick, m_env_tick;
   logic [2:0] m_step;

   always @(posedge clk or negedge rst_n) begin : model
      logic [7:0] rd_n;
      logic       wr;
      logic [2:0] a;
      logic [7:0] d;
      if (!rst_n) begin
         m_k = 0; m_power = 0; m_nr41 = 0; m_nr42 = 0; m_nr43 = 0; m_rdata = 8'hFF;
         m_len_en = 0; m_trig = 0; m_len_tick = 0; m_env_tick = 0; m_step = 0;
      end else begin
         wr = u_bus.wr_en; a = u_bus.addr; d = u_bus.wdata;
         rd_n = m_rdata;
`ifdef READBACK_EN
         if (u_bus.rd_en) begin
            case (a)
               3'd1:    rd_n = m_nr42;
               3'd2:    rd_n = m_nr43;
               3'd3:    rd_n = 8'hBF | (m_len_en ? 8'h40 : 8'h00);
               3'd4:    rd_n = m_power ? 8'hFF : 8'h7F;
               default: rd_n = 8'hFF;
            endcase
         end
`endif
         m_rdata = rd_n;
         m_trig = 0;
         if (m_power && wr && a == 3'd4 && !d[7]) begin
            m_k = 0; m_power = 0; m_nr41 = 0; m_nr42 = 0; m_nr43 = 0;
            m_len_en = 0; m_len_tick = 0; m_env_tick = 0; m_step = 0;
         end else begin
            if (m_power) begin
               m_k++;
               m_len_tick = (m_k % DIV == 0) && ((m_k / DIV) % 2 == 1);
               m_env_tick = (m_k % DIV == 0) && ((m_k / DIV) % 8 == 0);
               m_step     = 3'((m_k / DIV) % 8);
               if (wr) begin
                  case (a)
                     3'd0: m_nr41 = d[5:0];
                     3'd1: m_nr42 = d;
                     3'd2: m_nr43 = d;
                     3'd3: begin
                        m_len_en = d[6];
                        m_trig   = d[7] && (m_nr42 >= 8'h08);
                     end
                     default: ;
                  endcase
               end
            end else begin
               m_len_tick = 0;
               m_env_tick = 0;
            end
            if (wr && a == 3'd4) m_power = d[7];
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_length_load", 32'(o_length_load), 32'(m_nr41));
         chk("cyc_nr42_fields", {o_start_volume, o_env_add, o_env_period}, 32'(m_nr42));
         chk("cyc_nr43_fields", {o_clock_shift, o_width_mode, o_divisor_code}, 32'(m_nr43));
         chk("cyc_length_enable", 32'(o_length_enable), 32'(m_len_en));
         chk("cyc_trigger", 32'(o_trigger), 32'(m_trig));
         chk("cyc_len_tick", 32'(o_len_tick), 32'(m_len_tick));
         chk("cyc_env_tick", 32'(o_env_tick), 32'(m_env_tick));
         chk("cyc_dac", 32'(o_dac_enabled), 32'(m_nr42[7:3] != 5'd0));
         chk("cyc_power", 32'(o_power), 32'(m_power));
         chk("cyc_seq_step", 32'(o_seq_step), 32'(m_step));
         chk("cyc_rdata", 32'(u_bus.rdata), 32'(m_rdata));
      end
   end

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      u_bus.wr_en = 1'b1; u_bus.rd_en = 1'b0; u_bus.addr = a; u_bus.wdata = d;
      @(negedge clk);
   endtask

   task automatic rd(input logic [2:0] a);
      u_bus.wr_en = 1'b0; u_bus.rd_en = 1'b1; u_bus.addr = a;
      @(negedge clk);
      u_bus.rd_en = 1'b0;
   endtask

   task automatic idle();
      u_bus.wr_en = 1'b0; u_bus.rd_en = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n_len, n_env, first_len, last_len, first_env, last_env, ticks, found;
      logic [7:0] steps;
      rst_n = 1'b0;
      u_bus.wr_en = 0; u_bus.rd_en = 0; u_bus.addr = 0; u_bus.wdata = 0;
      @(negedge clk);
      cmp_en = 1'b1;
      cyc(2);
      chk("rst_rdata", 32'(u_bus.rdata), 32'hFF);
      chk("rst_power", 32'(o_power), 32'h0);
      chk("rst_seq_step", 32'(o_seq_step), 32'h0);
      rst_n = 1'b1;

      // Sequencer: 64 powered cycles
      wr(3'd4, 8'h80); idle();
      n_len = 0; n_env = 0; first_len = -1; last_len = -1; first_env = -1; last_env = -1; steps = 0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         steps[o_seq_step] = 1'b1;
         if (o_len_tick) begin
            n_len++; if (first_len < 0) first_len = i; last_len = i;
         end
         if (o_env_tick) begin
            n_env++; if (first_env < 0) first_env = i; last_env = i;
         end
      end
      chk("seq_len_count", 32'(n_len), 32'd8);
      chk("seq_env_count", 32'(n_env), 32'd2);
      chk("seq_first_len", 32'(first_len), 32'd4);
      chk("seq_len_span", 32'(last_len - first_len), 32'd56);
      chk("seq_env_span", 32'(last_env - first_env), 32'd32);
      chk("seq_steps_seen", 32'(steps), 32'hFF);

      // Configuration and trigger
      wr(3'd1, 8'hF3); wr(3'd2, 8'h3C); wr(3'd0, 8'h3F); wr(3'd3, 8'hC0); idle();
      chk("cfg_trigger_hi", 32'(o_trigger), 32'h1);
      chk("cfg_start_volume", 32'(o_start_volume), 32'hF);
      chk("cfg_env_add", 32'(o_env_add), 32'h0);
      chk("cfg_env_period", 32'(o_env_period), 32'h3);
      chk("cfg_clock_shift", 32'(o_clock_shift), 32'h3);
      chk("cfg_width_mode", 32'(o_width_mode), 32'h1);
      chk("cfg_divisor_code", 32'(o_divisor_code), 32'h4);
      chk("cfg_length_load", 32'(o_length_load), 32'd63);
      chk("cfg_length_enable", 32'(o_length_enable), 32'h1);
      cyc(1);
      chk("cfg_trigger_lo", 32'(o_trigger), 32'h0);

      // DAC off blocks trigger
      wr(3'd1, 8'h07); wr(3'd3, 8'h80); idle();
      chk("dacoff_dac", 32'(o_dac_enabled), 32'h0);
      chk("dacoff_trigger", 32'(o_trigger), 32'h0);
      cyc(1);
      chk("dacoff_trigger_next", 32'(o_trigger), 32'h0);

      // Back-to-back triggers
      wr(3'd1, 8'hF0); wr(3'd3, 8'h80);
      chk("b2b_trigger_1", 32'(o_trigger), 32'h1);
      wr(3'd3, 8'h80); idle();
      chk("b2b_trigger_2", 32'(o_trigger), 32'h1);
      cyc(1);
      chk("b2b_trigger_end", 32'(o_trigger), 32'h0);

      // Power off clears and ignores writes
      wr(3'd4, 8'h00); wr(3'd2, 8'hFF); idle();
      chk("poff_nr43", 32'({o_clock_shift, o_width_mode, o_divisor_code}), 32'h0);
      chk("poff_nr42", 32'({o_start_volume, o_env_add, o_env_period}), 32'h0);
      chk("poff_length_load", 32'(o_length_load), 32'h0);
      chk("poff_seq_step", 32'(o_seq_step), 32'h0);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ticks += int'(o_len_tick) + int'(o_env_tick);
      end
      chk("poff_no_ticks", 32'(ticks), 32'h0);
      wr(3'd4, 8'h80); idle();
      found = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (o_len_tick) begin found = i; break; end
      end
      chk("pon_first_len_delay", 32'(found), 32'(DIV));

      // Readback
      wr(3'd3, 8'h40); rd(3'd3);
      chk("rb_nr44_40", 32'(u_bus.rdata), 32'hFF);
      wr(3'd3, 8'h00); rd(3'd3);
`ifdef READBACK_EN
      chk("rb_nr44_00", 32'(u_bus.rdata), 32'hBF);
`else
      chk("rb_nr44_00", 32'(u_bus.rdata), 32'hFF);
`endif
      cyc(2);
`ifdef READBACK_EN
      chk("rb_hold", 32'(u_bus.rdata), 32'hBF);
`else
      chk("rb_hold", 32'(u_bus.rdata), 32'hFF);
`endif
      rd(3'd0);
      chk("rb_nr41", 32'(u_bus.rdata), 32'hFF);
      rd(3'd6);
      chk("rb_addr6", 32'(u_bus.rdata), 32'hFF);
      wr(3'd2, 8'h5A); rd(3'd2);
`ifdef READBACK_EN
      chk("rb_nr43", 32'(u_bus.rdata), 32'h5A);
`else
      chk("rb_nr43", 32'(u_bus.rdata), 32'hFF);
`endif

      // Reset mid-count with a trigger in flight
      wr(3'd1, 8'hF0);
      u_bus.wr_en = 1'b1; u_bus.addr = 3'd3; u_bus.wdata = 8'h80;
      @(posedge clk);
      #1;
      chk("mid_trigger_pending", 32'(o_trigger), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_trigger", 32'(o_trigger), 32'h0);
      chk("mid_rst_power", 32'(o_power), 32'h0);
      chk("mid_rst_cfg", 32'({o_start_volume, o_clock_shift, o_length_load}), 32'h0);
      chk("mid_rst_step", 32'(o_seq_step), 32'h0);
      chk("mid_rst_rdata", 32'(u_bus.rdata), 32'hFF);
      idle();
      cyc(2);
      rst_n = 1'b1;
      wr(3'd4, 8'h80); idle();
      ticks = 0;
      for (int i = 1; i < DIV; i++) begin
         @(negedge clk);
         ticks += int'(o_len_tick) + int'(o_env_tick);
      end
      chk("post_rst_no_early_tick", 32'(ticks), 32'h0);
      @(negedge clk);
      chk("post_rst_first_len", 32'(o_len_tick), 32'h1);
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/noise_channel_ctrl.md
Name: noise_channel_ctrl

Overview:
Register-bank and sequencing controller for the noise channel. Decodes CPU-side byte writes to the four noise registers and the master power register, then drives the channel's configuration inputs and a one-cycle trigger pulse. Contains the 512 Hz frame sequencer that issues the length (256 Hz) and envelope (64 Hz) tick enables. Sits between the CPU bus and the noise channel; its outputs map 1:1 onto the channel's config and trigger inputs.

Parameters:
DIV, 8192, system clocks per frame-sequencer step (4194304 Hz / 512 Hz); must be >= 2

Ports:
clk  input  1  system clock (4.194304 MHz)
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe, sampled on rising clk
rd_en  input  1  read strobe, sampled on rising clk
addr  input  3  0=NR41, 1=NR42, 2=NR43, 3=NR44, 4=NR52, 5-7 reserved
wdata  input  8  write data
rdata  output  8  registered read data
length_load  output  6  NR41[5:0]
start_volume  output  4  NR42[7:4]
env_add  output  1  NR42[3]
env_period  output  3  NR42[2:0]
clock_shift  output  4  NR43[7:4]
width_mode  output  1  NR43[3]
divisor_code  output  3  NR43[2:0]
trigger  output  1  one-cycle trigger pulse
length_enable  output  1  NR44[6]
len_tick  output  1  one-cycle 256 Hz length enable
env_tick  output  1  one-cycle 64 Hz envelope enable
dac_enabled  output  1  NR42[7:3] != 0 (combinational from register)
power  output  1  NR52[7]
seq_step  output  3  current frame-sequencer step

Behaviour:
- Reset (rst_n low, async): all registers 0, power 0, trigger/len_tick/env_tick 0, divider 0, seq_step 0, rdata 8'hFF.
- Writes: registered; a field changes on the rising edge where wr_en=1. Outputs reflect it from the next cycle (latency 1).
- NR41 write: length_load <= wdata[5:0]; wdata[7:6] ignored.
- NR42 write: stores the full byte. dac_enabled follows the stored value.
- NR43 write: stores the full byte.
- NR44 write: length_enable <= wdata[6]. If wdata[7]=1 and dac_enabled=1 (current stored NR42), trigger=1 for exactly the next cycle. If dac_enabled=0, no trigger pulse.
- Consecutive NR44 trigger writes on back-to-back cycles give back-to-back pulses; trigger is never wider than one cycle per write.
- NR52 write: power <= wdata[7]; other bits ignored.
- Power 1->0: on the same edge, clear NR41-NR44 state, clear trigger, divider and seq_step to 0, clear ticks.
- While power=0: writes to addr 0-3 ignored; the sequencer is held at step 0 / divider 0; no ticks.
- Power 0->1: the divider starts counting from 0 on the next cycle.
- Reserved addresses 5-7: writes ignored.
- Frame sequencer (power=1): divider counts 0..DIV-1 and wraps. On the edge where divider==DIV-1:
  - seq_step <= seq_step+1 (mod 8)
  - len_tick <= (old seq_step even)
  - env_tick <= (old seq_step==7)
  - On all other edges both ticks are 0.
- Result: len_tick rate is clk/(2*DIV) and env_tick rate is clk/(8*DIV). Tick pulses are one cycle wide.
- A trigger and a tick in the same cycle are independent; both assert.
- Reset asserted mid-operation aborts immediately to reset values. No pending trigger survives.

Optional Feature:
READBACK_EN
- Defined: on rd_en, rdata on the next cycle returns:
  - NR41: 8'hFF (write-only)
  - NR42: stored byte
  - NR43: stored byte
  - NR44: {1, length_enable, 6'h3F}
  - NR52: {power, 7'h7F}
  - addr 5-7: 8'hFF
  - rdata holds its value when rd_en=0.
- Undefined: rdata is constant 8'hFF and rd_en is ignored.

Test Plan:
- Reset: rst_n low mid-count with DIV=4 -> all outputs 0 (rdata FF) immediately, no ticks for 4 cycles after release plus power write.
- Power on, DIV=4, run 64 cycles -> len_tick asserted 8 times at 8-cycle spacing; env_tick asserted 2 times at 32-cycle spacing; seq_step cycles 0..7.
- Write NR42=8'hF3, NR43=8'h3C, NR41=8'h3F, NR44=8'hC0 -> start_volume=F, env_add=0, env_period=3, clock_shift=3, width_mode=1, divisor_code=4, length_load=63, length_enable=1, trigger high exactly one cycle after the NR44 write.
- NR42=8'h07 (DAC off), then NR44=8'h80 -> dac_enabled=0, trigger stays 0.
- Configure registers, write NR52=8'h00, then NR43=8'hFF -> all config outputs 0, NR43 write ignored, ticks stop, seq_step=0. Write NR52=8'h80 -> first len_tick arrives DIV cycles later.
- (READBACK_EN) Read NR44 after writing 8'h40 -> rdata=8'hFF; read NR44 after writing 8'h00 -> 8'hBF; read NR41 -> 8'hFF; read addr 6 -> 8'hFF.
